// File: rtl/mesh_router_sync.sv
// mesh_router_sync: five-port XY mesh router with per-input FIFOs, one-flit output registers and
// per-output round-robin arbitration. Define MESH_ROUTER_STATS_EN to add per-output flit counters.
module mesh_router_sync #(
  parameter int n     = 32,
  parameter int DEPTH = 4,
  parameter int XW    = 4,
  parameter int YW    = 4,
  parameter int srcx  = 0,
  parameter int srcy  = 0,
  parameter int maxx  = 1,
  parameter int maxy  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     in_req,
  input  logic [5*n-1:0] in_data,
  output logic [4:0]     in_ack,
  output logic [4:0]     out_req,
  output logic [5*n-1:0] out_data,
  input  logic [4:0]     out_ack,
`ifdef MESH_ROUTER_STATS_EN
  output logic [5*16-1:0] flit_cnt,
`endif
  output logic           drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] R_DROP = 3'd5;
  // Port index map: 0=LOCAL 1=NORTH 2=EAST 3=SOUTH 4=WEST
  localparam logic [4:0] PRESENT = {srcx != 0, srcy != 0, srcx != maxx, srcy != maxy, 1'b1};

  function automatic logic [2:0] route_of(input logic [XW+YW-1:0] dest);
    int dx;
    int dy;
    dx = int'(dest[XW-1:0]);
    dy = int'(dest[XW+YW-1:XW]);
    if (dx > maxx || dy > maxy) return R_DROP;
    else if (dx > srcx)         return 3'd2;
    else if (dx < srcx)         return 3'd4;
    else if (dy > srcy)         return 3'd1;
    else if (dy < srcy)         return 3'd3;
    else                        return 3'd0;
  endfunction

  // Search starts at the input after the last grant and wraps.
  function automatic logic [4:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
    logic [4:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= 5; k++) begin
      idx = (int'(p) + k) % 5;
      if (r[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [2:0] idx_of(input logic [4:0] g);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 5; k++)
      if (g[k]) r = 3'(k);
    return r;
  endfunction

  logic [4:0]          empty;
  logic [4:0][n-1:0]   head;
  logic [4:0][2:0]     route;
  logic [4:0]          drop_pop;
  logic [4:0][4:0]     grant;   // grant[output][input]
  logic                drop_q;

  genvar gi;

  for (gi = 0; gi < 5; gi++) begin : g_in
    if (PRESENT[gi]) begin : g_fifo
      logic [n-1:0]  mem_q [DEPTH];
      logic [AW-1:0] wr_q;
      logic [AW-1:0] rd_q;
      logic [CW-1:0] cnt_q;
      logic          push;
      logic          pop;

      assign in_ack[gi]   = (cnt_q != CW'(DEPTH));
      assign push         = in_req[gi] && in_ack[gi];
      assign empty[gi]    = (cnt_q == '0);
      assign head[gi]     = mem_q[rd_q];
      assign route[gi]    = route_of(mem_q[rd_q][XW+YW-1:0]);
      assign drop_pop[gi] = !empty[gi] && (route[gi] == R_DROP);
      // Each head routes to at most one output, so at most one of these is set.
      assign pop = drop_pop[gi] | grant[0][gi] | grant[1][gi] | grant[2][gi]
                 | grant[3][gi] | grant[4][gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          if (push) wr_q <= wr_q + 1'b1;
          if (pop)  rd_q <= rd_q + 1'b1;
          case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data[gi*n +: n];
      end
    end else begin : g_absent
      logic unused_in;
      assign unused_in    = ^{in_req[gi], in_data[gi*n +: n]};
      assign in_ack[gi]   = 1'b0;
      assign empty[gi]    = 1'b1;
      assign head[gi]     = '0;
      assign route[gi]    = 3'd0;
      assign drop_pop[gi] = 1'b0;
    end
  end

  for (gi = 0; gi < 5; gi++) begin : g_out
    if (PRESENT[gi]) begin : g_port
      logic [4:0]   reqs;
      logic         ld;
      logic [2:0]   ptr_q;
      logic         req_q;
      logic [n-1:0] data_q;
      logic [n-1:0] sel_data;

      for (genvar gj = 0; gj < 5; gj++) begin : g_req
        assign reqs[gj] = !empty[gj] && (route[gj] == 3'(gi));
      end

      assign ld        = !req_q || out_ack[gi];
      assign grant[gi] = ld ? rr_pick(reqs, ptr_q) : 5'b0;

      always_comb begin
        sel_data = '0;
        for (int k = 0; k < 5; k++)
          if (grant[gi][k]) sel_data = head[k];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          req_q  <= 1'b0;
          data_q <= '0;
          ptr_q  <= 3'd4;
        end else if (ld) begin
          req_q <= |grant[gi];
          if (|grant[gi]) begin
            data_q <= sel_data;
            ptr_q  <= idx_of(grant[gi]);
          end
        end
      end

      assign out_req[gi]         = req_q;
      assign out_data[gi*n +: n] = data_q;

`ifdef MESH_ROUTER_STATS_EN
      logic [15:0] cnt_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (req_q && out_ack[gi] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      assign flit_cnt[gi*16 +: 16] = cnt_q;
`endif
    end else begin : g_absent
      logic unused_out;
      assign unused_out          = out_ack[gi];
      assign grant[gi]           = 5'b0;
      assign out_req[gi]         = 1'b0;
      assign out_data[gi*n +: n] = '0;
`ifdef MESH_ROUTER_STATS_EN
      assign flit_cnt[gi*16 +: 16] = 16'd0;
`endif
    end
  end

  // Simultaneous drops from several inputs collapse into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= |drop_pop;
  end
  assign drop = drop_q;

endmodule

// File: tb/tb_mesh_router_sync.sv
// tb_mesh_router_sync: directed and randomized checks of a centre tile (1,1) and a corner
// tile (0,0) in a 3x3 mesh, scored against an XY-routing reference model.
module tb_mesh_router_sync;
  localparam int N  = 32;
  localparam int CX = 1;
  localparam int CY = 1;
  localparam int MX = 2;
  localparam int MY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]     c_in_req, c_in_ack, c_out_req, c_out_ack;
  logic [5*N-1:0] c_in_data, c_out_data;
  logic           c_drop;
  logic [4:0]     k_in_req, k_in_ack, k_out_req, k_out_ack;
  logic [5*N-1:0] k_in_data, k_out_data;
  logic           k_drop;
`ifdef MESH_ROUTER_STATS_EN
  logic [79:0]    c_flit_cnt, k_flit_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] sb [25][$];   // expected flits per (source, output) pair

  mesh_router_sync #(.n(N), .DEPTH(4), .XW(4), .YW(4), .srcx(CX), .srcy(CY), .maxx(MX), .maxy(MY))
  u_centre (
    .clk(clk), .rst(rst), .in_req(c_in_req), .in_data(c_in_data), .in_ack(c_in_ack),
    .out_req(c_out_req), .out_data(c_out_data), .out_ack(c_out_ack),
`ifdef MESH_ROUTER_STATS_EN
    .flit_cnt(c_flit_cnt),
`endif
    .drop(c_drop)
  );

  mesh_router_sync #(.n(N), .DEPTH(4), .XW(4), .YW(4), .srcx(0), .srcy(0), .maxx(MX), .maxy(MY))
  u_corner (
    .clk(clk), .rst(rst), .in_req(k_in_req), .in_data(k_in_data), .in_ack(k_in_ack),
    .out_req(k_out_req), .out_data(k_out_data), .out_ack(k_out_ack),
`ifdef MESH_ROUTER_STATS_EN
    .flit_cnt(k_flit_cnt),
`endif
    .drop(k_drop)
  );

  // XY dimension-order destination port at the centre tile.
  function automatic int exp_port(int dx, int dy);
    if (dx > CX) return 2;
    if (dx < CX) return 4;
    if (dy > CY) return 1;
    if (dy < CY) return 3;
    return 0;
  endfunction

  task automatic test_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (c_in_ack !== 5'b11111) begin errors++; $display("FAIL reset_in_ack got %b exp 11111", c_in_ack); end
    vectors++; if (c_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", c_drop); end
    vectors++; if (c_out_req !== 5'b0) begin errors++; $display("FAIL reset_out_req got %b exp 00000", c_out_req); end
    vectors++; if (k_in_ack !== 5'b00111) begin errors++; $display("FAIL reset_corner_in_ack got %b exp 00111", k_in_ack); end
    // park a flit in the NORTH output register, then reset mid-cycle
    c_out_ack = 5'b0;
    @(negedge clk); c_in_req[0] = 1'b1; c_in_data[0 +: N] = 32'h1234_0021;
    @(negedge clk); c_in_req[0] = 1'b0;
    @(negedge clk);
    vectors++; if (c_out_req !== 5'b00010) begin errors++; $display("FAIL reset_preload got %b exp 00010", c_out_req); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (c_out_req !== 5'b0) begin errors++; $display("FAIL reset_async_out_req got %b exp 00000", c_out_req); end
    vectors++; if (c_out_data !== '0) begin errors++; $display("FAIL reset_async_out_data got %h exp 0", c_out_data); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (c_in_ack !== 5'b11111) begin errors++; $display("FAIL reset_release_in_ack got %b exp 11111", c_in_ack); end
    vectors++; if (c_drop !== 1'b0) begin errors++; $display("FAIL reset_release_drop got %b exp 0", c_drop); end
    $display("test_reset done");
  endtask

  task automatic test_route();
    c_out_ack = 5'b0;
    @(negedge clk); c_in_req[0] = 1'b1; c_in_data[0 +: N] = 32'hA5A5_0021;
    vectors++; if (c_in_ack[0] !== 1'b1) begin errors++; $display("FAIL route_in_ack got %b exp 1", c_in_ack[0]); end
    @(negedge clk); c_in_req[0] = 1'b0;   // edge t has passed
    vectors++; if (c_out_req !== 5'b0) begin errors++; $display("FAIL route_early got %b exp 00000", c_out_req); end
    @(negedge clk);                        // edge t+1 has passed
    vectors++; if (c_out_req !== 5'b00010) begin errors++; $display("FAIL route_out_req got %b exp 00010", c_out_req); end
    vectors++; if (c_out_data[1*N +: N] !== 32'hA5A5_0021) begin errors++; $display("FAIL route_data got %h exp a5a50021", c_out_data[1*N +: N]); end
    c_out_ack[1] = 1'b1;
    @(negedge clk);
    vectors++; if (c_out_req !== 5'b0) begin errors++; $display("FAIL route_drain got %b exp 00000", c_out_req); end
    $display("test_route done");
  endtask

  task automatic test_contention();
    logic [31:0] got [$];
    logic [31:0] expv [6];
    for (int k = 0; k < 3; k++) begin
      expv[2*k]   = {16'h1000 + 16'(k), 16'h0011};
      expv[2*k+1] = {16'h4000 + 16'(k), 16'h0011};
    end
    c_out_ack = 5'b11111;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (c_out_req[0] && c_out_ack[0]) got.push_back(c_out_data[0 +: N]);
      if (cyc < 3) begin
        c_in_req = 5'b10010;
        c_in_data[1*N +: N] = {16'h1000 + 16'(cyc), 16'h0011};
        c_in_data[4*N +: N] = {16'h4000 + 16'(cyc), 16'h0011};
      end else begin
        c_in_req = 5'b0;
      end
    end
    vectors++; if (got.size() != 6) begin errors++; $display("FAIL contention_count got %0d exp 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (k >= got.size()) begin errors++; $display("FAIL contention_order[%0d] got none exp %h", k, expv[k]); end
      else if (got[k] !== expv[k]) begin errors++; $display("FAIL contention_order[%0d] got %h exp %h", k, got[k], expv[k]); end
    end
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic will;
    c_out_ack = 5'b11011;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      c_in_req[0] = 1'b1;
      c_in_data[0 +: N] = {16'hBB00 + 16'(acc), 16'h0012};
      will = c_in_ack[0];
      @(posedge clk);
      if (will) acc++;
    end
    @(negedge clk);
    vectors++; if (acc != 5) begin errors++; $display("FAIL bp_accepted got %0d exp 5", acc); end
    vectors++; if (c_in_ack[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ack got %b exp 0", c_in_ack[0]); end
    c_in_req[0] = 1'b0;
    c_out_ack[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (c_out_req[2] !== 1'b1 || c_out_data[2*N +: N] !== {16'hBB00 + 16'(k), 16'h0012}) begin
        errors++;
        $display("FAIL bp_drain[%0d] got req=%b data=%h exp req=1 data=%h", k, c_out_req[2],
                 c_out_data[2*N +: N], {16'hBB00 + 16'(k), 16'h0012});
      end
      @(negedge clk);
    end
    vectors++; if (c_out_req !== 5'b0) begin errors++; $display("FAIL bp_empty got %b exp 00000", c_out_req); end
    $display("test_backpressure done");
  endtask

  task automatic test_corner();
    int drops = 0;
    k_out_ack = 5'b11111;
    k_in_req  = 5'b11000;
    k_in_data[3*N +: N] = 32'hDEAD_0000;
    k_in_data[4*N +: N] = 32'hBEEF_0000;
    @(negedge clk); k_in_req[0] = 1'b1; k_in_data[0 +: N] = 32'hC0DE_0003;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      k_in_req[0] = 1'b0;
      if (k_drop === 1'b1) drops++;
      vectors++;
      if (k_in_ack[4:3] !== 2'b00 || k_out_req !== 5'b0 || k_out_data[5*N-1:3*N] !== '0) begin
        errors++;
        $display("FAIL corner_absent got in_ack=%b out_req=%b exp in_ack[4:3]=00 out_req=00000", k_in_ack, k_out_req);
      end
    end
    k_in_req = 5'b0;
    vectors++; if (drops != 1) begin errors++; $display("FAIL corner_drop_pulses got %0d exp 1", drops); end
    $display("test_corner done");
  endtask

  task automatic test_random();
    logic [4:0] pend = 5'b0;
    logic [15:0] seq [5] = '{default: 16'd0};
    int src, idx, op;
    logic [31:0] d, e;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      c_out_ack = (cyc < 450) ? 5'($urandom) : 5'b11111;
      for (int o = 0; o < 5; o++) begin
        if (c_out_req[o] && c_out_ack[o]) begin
          d = c_out_data[o*N +: N];
          src = int'(d[10:8]);
          vectors++;
          if (src > 4 || sb[src*5 + o].size() == 0) begin
            errors++; $display("FAIL rand_unexpected out=%0d got %h exp none", o, d);
          end else begin
            e = sb[src*5 + o].pop_front();
            if (d !== e) begin errors++; $display("FAIL rand_data out=%0d got %h exp %h", o, d, e); end
          end
        end
      end
      vectors++; if (c_drop !== 1'b0) begin errors++; $display("FAIL rand_drop got %b exp 0", c_drop); end
      for (int i = 0; i < 5; i++) begin
        if (!pend[i]) begin
          if (cyc < 450 && $urandom_range(0, 99) < 60) begin
            c_in_data[i*N +: N] = {seq[i], 5'($urandom), 3'(i), 4'($urandom_range(0, MY)), 4'($urandom_range(0, MX))};
            seq[i] = seq[i] + 16'd1;
            c_in_req[i] = 1'b1;
            pend[i] = 1'b1;
          end else begin
            c_in_req[i] = 1'b0;
          end
        end
        if (c_in_req[i] && c_in_ack[i]) begin
          d = c_in_data[i*N +: N];
          op = exp_port(int'(d[3:0]), int'(d[7:4]));
          idx = i*5 + op;
          sb[idx].push_back(d);
          pend[i] = 1'b0;
        end
      end
    end
    c_in_req = 5'b0;
    for (int q = 0; q < 25; q++) begin
      vectors++;
      if (sb[q].size() != 0) begin errors++; $display("FAIL rand_leftover src=%0d out=%0d got %0d exp 0", q/5, q%5, sb[q].size()); end
    end
    $display("test_random done");
  endtask

`ifdef MESH_ROUTER_STATS_EN
  task automatic test_stats();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    c_out_ack = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); c_in_req[0] = 1'b1; c_in_data[0 +: N] = {16'h5700 + 16'(k), 16'h0011};
    end
    @(negedge clk); c_in_req[0] = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (c_flit_cnt[15:0] !== 16'd3) begin errors++; $display("FAIL stats_local got %0d exp 3", c_flit_cnt[15:0]); end
    vectors++; if (c_flit_cnt[79:16] !== '0) begin errors++; $display("FAIL stats_others got %h exp 0", c_flit_cnt[79:16]); end
    $display("test_stats done");
  endtask
`endif

  initial begin
    c_in_req = '0; c_in_data = '0; c_out_ack = '0;
    k_in_req = '0; k_in_data = '0; k_out_ack = 5'b11111;
    repeat (2) @(posedge clk);
    test_reset();
    test_route();
    test_contention();
    test_backpressure();
    test_corner();
    test_random();
`ifdef MESH_ROUTER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0t exp completion", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mesh_router_sync.md
Name: mesh_router_sync

Overview:
- Parametrised synchronous successor of the click-based corner router.
- One router type covers corner, edge and centre tiles; the tile type is derived from srcx/srcy against maxx/maxy.
- Five ports: LOCAL, NORTH, EAST, SOUTH, WEST. Each input has a FIFO; each output has a one-flit output register.
- Routing is XY dimension-order with per-output round-robin arbitration. Single-flit packets.

Parameters:
- n, 32, flit width in bits.
- DEPTH, 4, input FIFO depth per port; power of two, at least 2.
- XW, 4, width of the destination-x field in bits.
- YW, 4, width of the destination-y field in bits.
- srcx, 0, this router's x coordinate.
- srcy, 0, this router's y coordinate.
- maxx, 1, highest x coordinate in the mesh.
- maxy, 1, highest y coordinate in the mesh.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_req  input  5  per-input flit valid; index 0=LOCAL, 1=NORTH, 2=EAST, 3=SOUTH, 4=WEST.
- in_data  input  5*n  per-input flit; slice i is [i*n +: n].
- in_ack  output  5  per-input ready.
- out_req  output  5  per-output flit valid; same index map.
- out_data  output  5*n  per-output flit.
- out_ack  input  5  per-output ready from the downstream router.
- drop  output  1  one-cycle pulse when a flit with an out-of-mesh destination is discarded.

Behaviour:
- Handshake: a transfer happens on a rising clk edge where req and ack are both 1.
  - req may not depend on ack.
  - data stays stable while req is high and ack is low.
- Flit fields: dest_x = data[XW-1:0], dest_y = data[XW+YW-1:XW]. The rest of the flit is payload and passes through unchanged.
- Direction convention: NORTH is y+1, EAST is x+1.
- Absent ports: NORTH is absent when srcy==maxy, SOUTH when srcy==0, EAST when srcx==maxx, WEST when srcx==0.
  - For an absent port, in_ack=0, out_req=0 and out_data=0 at all times.
  - Its logic is removed at elaboration.
- Route computation, on the FIFO head:
  - dest_x > maxx or dest_y > maxy: DROP.
  - else dest_x > srcx: EAST; dest_x < srcx: WEST.
  - else dest_y > srcy: NORTH; dest_y < srcy: SOUTH.
  - else LOCAL. LOCAL-to-LOCAL loopback is legal.
- DROP: the head is popped without arbitration and drop pulses high for one cycle. If two heads are dropped in the same cycle, each is still popped and drop is a single pulse.
- Input FIFO:
  - in_ack = !full, computed from the registered count.
  - Push and pop in the same cycle are legal, and the count is unchanged.
  - There is no bypass path: an empty FIFO cannot forward the flit arriving in the same cycle.
- Output register: can load when !out_req || out_ack, which allows back-to-back flits at one flit per cycle.
- Arbitration, per output:
  - Requesters are the non-empty inputs whose head routes to that output.
  - Priority order starts at the input after the last grant.
  - The pointer updates only on a grant. Reset value is 4, so LOCAL has first priority.
  - A grant pops the FIFO head and loads the output register in the same edge.
- Latency: a flit accepted at edge t is presented on out_req after edge t+1 when uncontended. Throughput is one flit per cycle per output.
- Order: flits from one input to one output leave in arrival order.
- Reset, asynchronous and valid mid-operation:
  - FIFOs are emptied; out_req=0, out_data=0, drop=0, pointers=4.
  - in_ack returns 1 for present ports on the first edge after rst deasserts.
  - In-flight flits are lost.

Optional Feature:
- MESH_ROUTER_STATS_EN defined: adds output port flit_cnt, 5*16 bits.
  - Holds one saturating counter per output, incremented on each out_req&&out_ack.
  - Counters stop at 16'hFFFF and clear on rst.
- Undefined: the port and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: srcx=1, srcy=1, maxx=2, maxy=2; assert rst mid-cycle.
  - Expect out_req=0 immediately.
  - After release, in_ack=5'b11111, drop=0.
- Uncontended route: LOCAL flit 0xA5A5_0021, meaning dx=1, dy=2, accepted at edge t.
  - Expect out_req[NORTH]=1 after edge t+1 with identical data; no other output is active.
- Contention: NORTH and WEST each inject 3 flits to (1,1), with the LOCAL output always ready.
  - Expect the LOCAL output order N, W, N, W, N, W; no loss and no duplication.
- Backpressure: out_ack[EAST]=0, DEPTH=4; LOCAL streams flits to (2,1).
  - Expect exactly 5 accepted before in_ack[LOCAL]=0 (4 in the FIFO, 1 in the output register).
  - Release out_ack; all 5 exit in order at one per cycle.
- Corner tile: srcx=0, srcy=0.
  - Expect in_ack[SOUTH]=in_ack[WEST]=0 and out_req[SOUTH]=out_req[WEST]=0 throughout.
  - Inject a LOCAL flit to (3,0) with maxx=2: expect a single drop pulse and no out_req.
- Stats (macro on): send 3 flits LOCAL to LOCAL.
  - Expect flit_cnt[LOCAL]=3 and all other counters 0.
